// File: rtl/axi_atomics_arbiter_pkg.sv
// Shared types and width helpers for the two-master AXI4+ATOP arbiter.
package axi_atomics_arbiter_pkg;

  typedef logic src_t;

  localparam src_t SRC_M0 = 1'b0;
  localparam src_t SRC_M1 = 1'b1;

  function automatic int ext_id_width(input int id_width);
    return id_width + 1;
  endfunction

  function automatic int strb_width(input int data_width);
    return data_width / 8;
  endfunction

endpackage

// File: rtl/axi_atomics_arb_fifo.sv
// Small synchronous FIFO; here it remembers which master owns each pending W burst.
module axi_atomics_arb_fifo #(
  parameter int  DEPTH = 4,
  parameter type T     = logic
) (
  input  logic CLK,
  input  logic areset,
  input  logic push,
  input  T     push_data,
  input  logic pop,
  output logic full,
  output logic empty,
  output T     head
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  T                 mem_q [DEPTH];
  logic             push_ok, pop_ok;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign head    = mem_q[rd_ptr_q];
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge CLK or posedge areset) begin
    if (areset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= next_ptr(wr_ptr_q);
      if (pop_ok)  rd_ptr_q <= next_ptr(rd_ptr_q);
      if (push_ok && !pop_ok)      count_q <= count_q + CNT_W'(1);
      else if (pop_ok && !push_ok) count_q <= count_q - CNT_W'(1);
    end
  end

  // NOTE: storage is deliberately not reset; empty/full come from the reset count, so stale entries are never read.
  always_ff @(posedge CLK) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/axi_atomics_arbiter.sv
// Two-master AXI4+ATOP arbiter in front of the atomics adapter; source bit prepended to AW/AR IDs.
module axi_atomics_arbiter
  import axi_atomics_arbiter_pkg::*;
#(
  parameter int AXI_ADDR_WIDTH     = 64,
  parameter int AXI_DATA_WIDTH     = 64,
  parameter int AXI_ID_WIDTH       = 4,
  parameter int AXI_USER_WIDTH     = 1,
  parameter int AXI_MAX_WRITE_TXNS = 4,
  localparam int XID_W  = ext_id_width(AXI_ID_WIDTH),
  localparam int STRB_W = strb_width(AXI_DATA_WIDTH)
) (
  input  logic CLK,
  input  logic areset,
  // requester ports: AW / W
  input  logic [AXI_ID_WIDTH-1:0]   s0_axi_awid, s1_axi_awid,
  input  logic [AXI_ADDR_WIDTH-1:0] s0_axi_awaddr, s1_axi_awaddr,
  input  logic [7:0]                s0_axi_awlen, s1_axi_awlen,
  input  logic [2:0]                s0_axi_awsize, s1_axi_awsize, s0_axi_awprot, s1_axi_awprot,
  input  logic [1:0]                s0_axi_awburst, s1_axi_awburst,
  input  logic                      s0_axi_awlock, s1_axi_awlock,
  input  logic [3:0]                s0_axi_awcache, s1_axi_awcache, s0_axi_awqos, s1_axi_awqos,
  input  logic [3:0]                s0_axi_awregion, s1_axi_awregion,
  input  logic [5:0]                s0_axi_awatop, s1_axi_awatop,
  input  logic [AXI_USER_WIDTH-1:0] s0_axi_awuser, s1_axi_awuser,
  input  logic                      s0_axi_awvalid, s1_axi_awvalid,
  output logic                      s0_axi_awready, s1_axi_awready,
  input  logic [AXI_DATA_WIDTH-1:0] s0_axi_wdata, s1_axi_wdata,
  input  logic [STRB_W-1:0]         s0_axi_wstrb, s1_axi_wstrb,
  input  logic                      s0_axi_wlast, s1_axi_wlast,
  input  logic [AXI_USER_WIDTH-1:0] s0_axi_wuser, s1_axi_wuser,
  input  logic                      s0_axi_wvalid, s1_axi_wvalid,
  output logic                      s0_axi_wready, s1_axi_wready,
  // requester ports: B
  output logic [AXI_ID_WIDTH-1:0]   s0_axi_bid, s1_axi_bid,
  output logic [1:0]                s0_axi_bresp, s1_axi_bresp,
  output logic [AXI_USER_WIDTH-1:0] s0_axi_buser, s1_axi_buser,
  output logic                      s0_axi_bvalid, s1_axi_bvalid,
  input  logic                      s0_axi_bready, s1_axi_bready,
  // requester ports: AR / R
  input  logic [AXI_ID_WIDTH-1:0]   s0_axi_arid, s1_axi_arid,
  input  logic [AXI_ADDR_WIDTH-1:0] s0_axi_araddr, s1_axi_araddr,
  input  logic [7:0]                s0_axi_arlen, s1_axi_arlen,
  input  logic [2:0]                s0_axi_arsize, s1_axi_arsize, s0_axi_arprot, s1_axi_arprot,
  input  logic [1:0]                s0_axi_arburst, s1_axi_arburst,
  input  logic                      s0_axi_arlock, s1_axi_arlock,
  input  logic [3:0]                s0_axi_arcache, s1_axi_arcache, s0_axi_arqos, s1_axi_arqos,
  input  logic [3:0]                s0_axi_arregion, s1_axi_arregion,
  input  logic [AXI_USER_WIDTH-1:0] s0_axi_aruser, s1_axi_aruser,
  input  logic                      s0_axi_arvalid, s1_axi_arvalid,
  output logic                      s0_axi_arready, s1_axi_arready,
  output logic [AXI_ID_WIDTH-1:0]   s0_axi_rid, s1_axi_rid,
  output logic [AXI_DATA_WIDTH-1:0] s0_axi_rdata, s1_axi_rdata,
  output logic [1:0]                s0_axi_rresp, s1_axi_rresp,
  output logic                      s0_axi_rlast, s1_axi_rlast,
  output logic [AXI_USER_WIDTH-1:0] s0_axi_ruser, s1_axi_ruser,
  output logic                      s0_axi_rvalid, s1_axi_rvalid,
  input  logic                      s0_axi_rready, s1_axi_rready,
  // adapter port
  output logic [XID_W-1:0]          m_axi_out_awid,
  output logic [AXI_ADDR_WIDTH-1:0] m_axi_out_awaddr,
  output logic [7:0]                m_axi_out_awlen,
  output logic [2:0]                m_axi_out_awsize, m_axi_out_awprot,
  output logic [1:0]                m_axi_out_awburst,
  output logic                      m_axi_out_awlock,
  output logic [3:0]                m_axi_out_awcache, m_axi_out_awqos, m_axi_out_awregion,
  output logic [5:0]                m_axi_out_awatop,
  output logic [AXI_USER_WIDTH-1:0] m_axi_out_awuser,
  output logic                      m_axi_out_awvalid,
  input  logic                      m_axi_out_awready,
  output logic [AXI_DATA_WIDTH-1:0] m_axi_out_wdata,
  output logic [STRB_W-1:0]         m_axi_out_wstrb,
  output logic                      m_axi_out_wlast,
  output logic [AXI_USER_WIDTH-1:0] m_axi_out_wuser,
  output logic                      m_axi_out_wvalid,
  input  logic                      m_axi_out_wready,
  input  logic [XID_W-1:0]          m_axi_out_bid,
  input  logic [1:0]                m_axi_out_bresp,
  input  logic [AXI_USER_WIDTH-1:0] m_axi_out_buser,
  input  logic                      m_axi_out_bvalid,
  output logic                      m_axi_out_bready,
  output logic [XID_W-1:0]          m_axi_out_arid,
  output logic [AXI_ADDR_WIDTH-1:0] m_axi_out_araddr,
  output logic [7:0]                m_axi_out_arlen,
  output logic [2:0]                m_axi_out_arsize, m_axi_out_arprot,
  output logic [1:0]                m_axi_out_arburst,
  output logic                      m_axi_out_arlock,
  output logic [3:0]                m_axi_out_arcache, m_axi_out_arqos, m_axi_out_arregion,
  output logic [AXI_USER_WIDTH-1:0] m_axi_out_aruser,
  output logic                      m_axi_out_arvalid,
  input  logic                      m_axi_out_arready,
  input  logic [XID_W-1:0]          m_axi_out_rid,
  input  logic [AXI_DATA_WIDTH-1:0] m_axi_out_rdata,
  input  logic [1:0]                m_axi_out_rresp,
  input  logic                      m_axi_out_rlast,
  input  logic [AXI_USER_WIDTH-1:0] m_axi_out_ruser,
  input  logic                      m_axi_out_rvalid,
  output logic                      m_axi_out_rready
);

  src_t aw_ptr_q, aw_lock_src_q, aw_gnt, ar_ptr_q, ar_lock_src_q, ar_gnt;
  logic aw_lock_q, ar_lock_q, aw_req, ar_req, aw_hs, ar_hs;
  logic w_full, w_empty, w_pop;
  src_t w_head;

  // A locked grant sticks to its source; otherwise the pointer's master wins, else the other one.
  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    aw_gnt = aw_ptr_q;
    if (aw_lock_q)                                        aw_gnt = aw_lock_src_q;
    else if (!(aw_ptr_q ? s1_axi_awvalid : s0_axi_awvalid)) aw_gnt = ~aw_ptr_q;
    ar_gnt = ar_ptr_q;
    if (ar_lock_q)                                        ar_gnt = ar_lock_src_q;
    else if (!(ar_ptr_q ? s1_axi_arvalid : s0_axi_arvalid)) ar_gnt = ~ar_ptr_q;
  end

  assign aw_req = aw_gnt ? s1_axi_awvalid : s0_axi_awvalid;
  assign ar_req = ar_gnt ? s1_axi_arvalid : s0_axi_arvalid;

  assign m_axi_out_awvalid = aw_req && !w_full && !areset;
  assign m_axi_out_arvalid = ar_req && !areset;
  assign aw_hs             = m_axi_out_awvalid && m_axi_out_awready;
  assign ar_hs             = m_axi_out_arvalid && m_axi_out_arready;
  assign s0_axi_awready    = aw_hs && (aw_gnt == SRC_M0);
  assign s1_axi_awready    = aw_hs && (aw_gnt == SRC_M1);
  assign s0_axi_arready    = ar_hs && (ar_gnt == SRC_M0);
  assign s1_axi_arready    = ar_hs && (ar_gnt == SRC_M1);

  always_ff @(posedge CLK or posedge areset) begin
    if (areset) begin
      aw_ptr_q      <= SRC_M0;
      aw_lock_q     <= 1'b0;
      aw_lock_src_q <= SRC_M0;
      ar_ptr_q      <= SRC_M0;
      ar_lock_q     <= 1'b0;
      ar_lock_src_q <= SRC_M0;
    end else begin
      if (aw_hs) begin
        aw_ptr_q  <= ~aw_gnt;
        aw_lock_q <= 1'b0;
      end else if (m_axi_out_awvalid) begin
        aw_lock_q     <= 1'b1;
        aw_lock_src_q <= aw_gnt;
      end
      if (ar_hs) begin
        ar_ptr_q  <= ~ar_gnt;
        ar_lock_q <= 1'b0;
      end else if (m_axi_out_arvalid) begin
        ar_lock_q     <= 1'b1;
        ar_lock_src_q <= ar_gnt;
      end
    end
  end

  assign m_axi_out_awid     = {aw_gnt, aw_gnt ? s1_axi_awid : s0_axi_awid};
  assign m_axi_out_awaddr   = aw_gnt ? s1_axi_awaddr   : s0_axi_awaddr;
  assign m_axi_out_awlen    = aw_gnt ? s1_axi_awlen    : s0_axi_awlen;
  assign m_axi_out_awsize   = aw_gnt ? s1_axi_awsize   : s0_axi_awsize;
  assign m_axi_out_awburst  = aw_gnt ? s1_axi_awburst  : s0_axi_awburst;
  assign m_axi_out_awlock   = aw_gnt ? s1_axi_awlock   : s0_axi_awlock;
  assign m_axi_out_awcache  = aw_gnt ? s1_axi_awcache  : s0_axi_awcache;
  assign m_axi_out_awprot   = aw_gnt ? s1_axi_awprot   : s0_axi_awprot;
  assign m_axi_out_awqos    = aw_gnt ? s1_axi_awqos    : s0_axi_awqos;
  assign m_axi_out_awregion = aw_gnt ? s1_axi_awregion : s0_axi_awregion;
  assign m_axi_out_awatop   = aw_gnt ? s1_axi_awatop   : s0_axi_awatop;
  assign m_axi_out_awuser   = aw_gnt ? s1_axi_awuser   : s0_axi_awuser;

  assign m_axi_out_arid     = {ar_gnt, ar_gnt ? s1_axi_arid : s0_axi_arid};
  assign m_axi_out_araddr   = ar_gnt ? s1_axi_araddr   : s0_axi_araddr;
  assign m_axi_out_arlen    = ar_gnt ? s1_axi_arlen    : s0_axi_arlen;
  assign m_axi_out_arsize   = ar_gnt ? s1_axi_arsize   : s0_axi_arsize;
  assign m_axi_out_arburst  = ar_gnt ? s1_axi_arburst  : s0_axi_arburst;
  assign m_axi_out_arlock   = ar_gnt ? s1_axi_arlock   : s0_axi_arlock;
  assign m_axi_out_arcache  = ar_gnt ? s1_axi_arcache  : s0_axi_arcache;
  assign m_axi_out_arprot   = ar_gnt ? s1_axi_arprot   : s0_axi_arprot;
  assign m_axi_out_arqos    = ar_gnt ? s1_axi_arqos    : s0_axi_arqos;
  assign m_axi_out_arregion = ar_gnt ? s1_axi_arregion : s0_axi_arregion;
  assign m_axi_out_aruser   = ar_gnt ? s1_axi_aruser   : s0_axi_aruser;

  // W is steered by the oldest accepted AW; an AW pushed this cycle only opens W next cycle.
  axi_atomics_arb_fifo #(.DEPTH(AXI_MAX_WRITE_TXNS), .T(src_t)) u_w_order (
    .CLK      (CLK),
    .areset   (areset),
    .push     (aw_hs),
    .push_data(aw_gnt),
    .pop      (w_pop),
    .full     (w_full),
    .empty    (w_empty),
    .head     (w_head)
  );

  assign m_axi_out_wvalid = !w_empty && !areset && (w_head ? s1_axi_wvalid : s0_axi_wvalid);
  assign m_axi_out_wdata  = w_head ? s1_axi_wdata : s0_axi_wdata;
  assign m_axi_out_wstrb  = w_head ? s1_axi_wstrb : s0_axi_wstrb;
  assign m_axi_out_wlast  = w_head ? s1_axi_wlast : s0_axi_wlast;
  assign m_axi_out_wuser  = w_head ? s1_axi_wuser : s0_axi_wuser;
  assign s0_axi_wready    = !w_empty && !areset && (w_head == SRC_M0) && m_axi_out_wready;
  assign s1_axi_wready    = !w_empty && !areset && (w_head == SRC_M1) && m_axi_out_wready;
  assign w_pop            = m_axi_out_wvalid && m_axi_out_wready && m_axi_out_wlast;

  // Responses carry their destination in the ID MSB, so B and R routing is stateless.
  assign s0_axi_bvalid    = m_axi_out_bvalid && !m_axi_out_bid[AXI_ID_WIDTH] && !areset;
  assign s1_axi_bvalid    = m_axi_out_bvalid &&  m_axi_out_bid[AXI_ID_WIDTH] && !areset;
  assign m_axi_out_bready = !areset && (m_axi_out_bid[AXI_ID_WIDTH] ? s1_axi_bready : s0_axi_bready);
  assign s0_axi_bid       = m_axi_out_bid[AXI_ID_WIDTH-1:0];
  assign s1_axi_bid       = m_axi_out_bid[AXI_ID_WIDTH-1:0];
  assign s0_axi_bresp     = m_axi_out_bresp;
  assign s1_axi_bresp     = m_axi_out_bresp;
  assign s0_axi_buser     = m_axi_out_buser;
  assign s1_axi_buser     = m_axi_out_buser;

  assign s0_axi_rvalid    = m_axi_out_rvalid && !m_axi_out_rid[AXI_ID_WIDTH] && !areset;
  assign s1_axi_rvalid    = m_axi_out_rvalid &&  m_axi_out_rid[AXI_ID_WIDTH] && !areset;
  assign m_axi_out_rready = !areset && (m_axi_out_rid[AXI_ID_WIDTH] ? s1_axi_rready : s0_axi_rready);
  assign s0_axi_rid       = m_axi_out_rid[AXI_ID_WIDTH-1:0];
  assign s1_axi_rid       = m_axi_out_rid[AXI_ID_WIDTH-1:0];
  assign s0_axi_rdata     = m_axi_out_rdata;
  assign s1_axi_rdata     = m_axi_out_rdata;
  assign s0_axi_rresp     = m_axi_out_rresp;
  assign s1_axi_rresp     = m_axi_out_rresp;
  assign s0_axi_rlast     = m_axi_out_rlast;
  assign s1_axi_rlast     = m_axi_out_rlast;
  assign s0_axi_ruser     = m_axi_out_ruser;
  assign s1_axi_ruser     = m_axi_out_ruser;

endmodule

// File: tb/tb_axi_atomics_arbiter.sv
// Directed bench: response-routing vector table plus hand-written arbitration/ordering sequences.
module tb_axi_atomics_arbiter;

  localparam int IDW = 4;
  localparam int XW  = 5;
  localparam int AW  = 64;
  localparam int DW  = 64;
  localparam int UW  = 1;

  logic CLK = 1'b0;
  logic areset;
  always #5 CLK = ~CLK;

  logic [IDW-1:0] s0_axi_awid, s1_axi_awid, s0_axi_arid, s1_axi_arid;
  logic [AW-1:0]  s0_axi_awaddr, s1_axi_awaddr, s0_axi_araddr, s1_axi_araddr;
  logic [7:0]     s0_axi_awlen, s1_axi_awlen, s0_axi_arlen, s1_axi_arlen;
  logic [2:0]     s0_axi_awsize, s1_axi_awsize, s0_axi_awprot, s1_axi_awprot;
  logic [2:0]     s0_axi_arsize, s1_axi_arsize, s0_axi_arprot, s1_axi_arprot;
  logic [1:0]     s0_axi_awburst, s1_axi_awburst, s0_axi_arburst, s1_axi_arburst;
  logic           s0_axi_awlock, s1_axi_awlock, s0_axi_arlock, s1_axi_arlock;
  logic [3:0]     s0_axi_awcache, s1_axi_awcache, s0_axi_awqos, s1_axi_awqos;
  logic [3:0]     s0_axi_awregion, s1_axi_awregion, s0_axi_arregion, s1_axi_arregion;
  logic [3:0]     s0_axi_arcache, s1_axi_arcache, s0_axi_arqos, s1_axi_arqos;
  logic [5:0]     s0_axi_awatop, s1_axi_awatop;
  logic [UW-1:0]  s0_axi_awuser, s1_axi_awuser, s0_axi_aruser, s1_axi_aruser;
  logic [UW-1:0]  s0_axi_wuser, s1_axi_wuser, s0_axi_buser, s1_axi_buser, s0_axi_ruser, s1_axi_ruser;
  logic           s0_axi_awvalid, s1_axi_awvalid, s0_axi_awready, s1_axi_awready;
  logic           s0_axi_arvalid, s1_axi_arvalid, s0_axi_arready, s1_axi_arready;
  logic [DW-1:0]  s0_axi_wdata, s1_axi_wdata, s0_axi_rdata, s1_axi_rdata;
  logic [DW/8-1:0] s0_axi_wstrb, s1_axi_wstrb;
  logic           s0_axi_wlast, s1_axi_wlast, s0_axi_wvalid, s1_axi_wvalid, s0_axi_wready, s1_axi_wready;
  logic [IDW-1:0] s0_axi_bid, s1_axi_bid, s0_axi_rid, s1_axi_rid;
  logic [1:0]     s0_axi_bresp, s1_axi_bresp, s0_axi_rresp, s1_axi_rresp;
  logic           s0_axi_bvalid, s1_axi_bvalid, s0_axi_bready, s1_axi_bready;
  logic           s0_axi_rlast, s1_axi_rlast, s0_axi_rvalid, s1_axi_rvalid, s0_axi_rready, s1_axi_rready;

  logic [XW-1:0]  m_axi_out_awid, m_axi_out_arid, m_axi_out_bid, m_axi_out_rid;
  logic [AW-1:0]  m_axi_out_awaddr, m_axi_out_araddr;
  logic [7:0]     m_axi_out_awlen, m_axi_out_arlen;
  logic [2:0]     m_axi_out_awsize, m_axi_out_awprot, m_axi_out_arsize, m_axi_out_arprot;
  logic [1:0]     m_axi_out_awburst, m_axi_out_arburst, m_axi_out_bresp, m_axi_out_rresp;
  logic           m_axi_out_awlock, m_axi_out_arlock;
  logic [3:0]     m_axi_out_awcache, m_axi_out_awqos, m_axi_out_awregion;
  logic [3:0]     m_axi_out_arcache, m_axi_out_arqos, m_axi_out_arregion;
  logic [5:0]     m_axi_out_awatop;
  logic [UW-1:0]  m_axi_out_awuser, m_axi_out_aruser, m_axi_out_wuser, m_axi_out_buser, m_axi_out_ruser;
  logic           m_axi_out_awvalid, m_axi_out_awready, m_axi_out_arvalid, m_axi_out_arready;
  logic [DW-1:0]  m_axi_out_wdata, m_axi_out_rdata;
  logic [DW/8-1:0] m_axi_out_wstrb;
  logic           m_axi_out_wlast, m_axi_out_wvalid, m_axi_out_wready;
  logic           m_axi_out_bvalid, m_axi_out_bready, m_axi_out_rlast, m_axi_out_rvalid, m_axi_out_rready;

  axi_atomics_arbiter dut (
    .CLK(CLK), .areset(areset),
    .s0_axi_awid(s0_axi_awid), .s1_axi_awid(s1_axi_awid),
    .s0_axi_awaddr(s0_axi_awaddr), .s1_axi_awaddr(s1_axi_awaddr),
    .s0_axi_awlen(s0_axi_awlen), .s1_axi_awlen(s1_axi_awlen),
    .s0_axi_awsize(s0_axi_awsize), .s1_axi_awsize(s1_axi_awsize),
    .s0_axi_awprot(s0_axi_awprot), .s1_axi_awprot(s1_axi_awprot),
    .s0_axi_awburst(s0_axi_awburst), .s1_axi_awburst(s1_axi_awburst),
    .s0_axi_awlock(s0_axi_awlock), .s1_axi_awlock(s1_axi_awlock),
    .s0_axi_awcache(s0_axi_awcache), .s1_axi_awcache(s1_axi_awcache),
    .s0_axi_awqos(s0_axi_awqos), .s1_axi_awqos(s1_axi_awqos),
    .s0_axi_awregion(s0_axi_awregion), .s1_axi_awregion(s1_axi_awregion),
    .s0_axi_awatop(s0_axi_awatop), .s1_axi_awatop(s1_axi_awatop),
    .s0_axi_awuser(s0_axi_awuser), .s1_axi_awuser(s1_axi_awuser),
    .s0_axi_awvalid(s0_axi_awvalid), .s1_axi_awvalid(s1_axi_awvalid),
    .s0_axi_awready(s0_axi_awready), .s1_axi_awready(s1_axi_awready),
    .s0_axi_wdata(s0_axi_wdata), .s1_axi_wdata(s1_axi_wdata),
    .s0_axi_wstrb(s0_axi_wstrb), .s1_axi_wstrb(s1_axi_wstrb),
    .s0_axi_wlast(s0_axi_wlast), .s1_axi_wlast(s1_axi_wlast),
    .s0_axi_wuser(s0_axi_wuser), .s1_axi_wuser(s1_axi_wuser),
    .s0_axi_wvalid(s0_axi_wvalid), .s1_axi_wvalid(s1_axi_wvalid),
    .s0_axi_wready(s0_axi_wready), .s1_axi_wready(s1_axi_wready),
    .s0_axi_bid(s0_axi_bid), .s1_axi_bid(s1_axi_bid),
    .s0_axi_bresp(s0_axi_bresp), .s1_axi_bresp(s1_axi_bresp),
    .s0_axi_buser(s0_axi_buser), .s1_axi_buser(s1_axi_buser),
    .s0_axi_bvalid(s0_axi_bvalid), .s1_axi_bvalid(s1_axi_bvalid),
    .s0_axi_bready(s0_axi_bready), .s1_axi_bready(s1_axi_bready),
    .s0_axi_arid(s0_axi_arid), .s1_axi_arid(s1_axi_arid),
    .s0_axi_araddr(s0_axi_araddr), .s1_axi_araddr(s1_axi_araddr),
    .s0_axi_arlen(s0_axi_arlen), .s1_axi_arlen(s1_axi_arlen),
    .s0_axi_arsize(s0_axi_arsize), .s1_axi_arsize(s1_axi_arsize),
    .s0_axi_arprot(s0_axi_arprot), .s1_axi_arprot(s1_axi_arprot),
    .s0_axi_arburst(s0_axi_arburst), .s1_axi_arburst(s1_axi_arburst),
    .s0_axi_arlock(s0_axi_arlock), .s1_axi_arlock(s1_axi_arlock),
    .s0_axi_arcache(s0_axi_arcache), .s1_axi_arcache(s1_axi_arcache),
    .s0_axi_arqos(s0_axi_arqos), .s1_axi_arqos(s1_axi_arqos),
    .s0_axi_arregion(s0_axi_arregion), .s1_axi_arregion(s1_axi_arregion),
    .s0_axi_aruser(s0_axi_aruser), .s1_axi_aruser(s1_axi_aruser),
    .s0_axi_arvalid(s0_axi_arvalid), .s1_axi_arvalid(s1_axi_arvalid),
    .s0_axi_arready(s0_axi_arready), .s1_axi_arready(s1_axi_arready),
    .s0_axi_rid(s0_axi_rid), .s1_axi_rid(s1_axi_rid),
    .s0_axi_rdata(s0_axi_rdata), .s1_axi_rdata(s1_axi_rdata),
    .s0_axi_rresp(s0_axi_rresp), .s1_axi_rresp(s1_axi_rresp),
    .s0_axi_rlast(s0_axi_rlast), .s1_axi_rlast(s1_axi_rlast),
    .s0_axi_ruser(s0_axi_ruser), .s1_axi_ruser(s1_axi_ruser),
    .s0_axi_rvalid(s0_axi_rvalid), .s1_axi_rvalid(s1_axi_rvalid),
    .s0_axi_rready(s0_axi_rready), .s1_axi_rready(s1_axi_rready),
    .m_axi_out_awid(m_axi_out_awid), .m_axi_out_awaddr(m_axi_out_awaddr),
    .m_axi_out_awlen(m_axi_out_awlen), .m_axi_out_awsize(m_axi_out_awsize),
    .m_axi_out_awprot(m_axi_out_awprot), .m_axi_out_awburst(m_axi_out_awburst),
    .m_axi_out_awlock(m_axi_out_awlock), .m_axi_out_awcache(m_axi_out_awcache),
    .m_axi_out_awqos(m_axi_out_awqos), .m_axi_out_awregion(m_axi_out_awregion),
    .m_axi_out_awatop(m_axi_out_awatop), .m_axi_out_awuser(m_axi_out_awuser),
    .m_axi_out_awvalid(m_axi_out_awvalid), .m_axi_out_awready(m_axi_out_awready),
    .m_axi_out_wdata(m_axi_out_wdata), .m_axi_out_wstrb(m_axi_out_wstrb),
    .m_axi_out_wlast(m_axi_out_wlast), .m_axi_out_wuser(m_axi_out_wuser),
    .m_axi_out_wvalid(m_axi_out_wvalid), .m_axi_out_wready(m_axi_out_wready),
    .m_axi_out_bid(m_axi_out_bid), .m_axi_out_bresp(m_axi_out_bresp),
    .m_axi_out_buser(m_axi_out_buser), .m_axi_out_bvalid(m_axi_out_bvalid),
    .m_axi_out_bready(m_axi_out_bready),
    .m_axi_out_arid(m_axi_out_arid), .m_axi_out_araddr(m_axi_out_araddr),
    .m_axi_out_arlen(m_axi_out_arlen), .m_axi_out_arsize(m_axi_out_arsize),
    .m_axi_out_arprot(m_axi_out_arprot), .m_axi_out_arburst(m_axi_out_arburst),
    .m_axi_out_arlock(m_axi_out_arlock), .m_axi_out_arcache(m_axi_out_arcache),
    .m_axi_out_arqos(m_axi_out_arqos), .m_axi_out_arregion(m_axi_out_arregion),
    .m_axi_out_aruser(m_axi_out_aruser), .m_axi_out_arvalid(m_axi_out_arvalid),
    .m_axi_out_arready(m_axi_out_arready),
    .m_axi_out_rid(m_axi_out_rid), .m_axi_out_rdata(m_axi_out_rdata),
    .m_axi_out_rresp(m_axi_out_rresp), .m_axi_out_rlast(m_axi_out_rlast),
    .m_axi_out_ruser(m_axi_out_ruser), .m_axi_out_rvalid(m_axi_out_rvalid),
    .m_axi_out_rready(m_axi_out_rready)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Inputs change 1 ns after the rising edge; outputs are sampled 1 ns later.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic clear_inputs();
    {s0_axi_awid, s1_axi_awid, s0_axi_arid, s1_axi_arid} = '0;
    {s0_axi_awaddr, s1_axi_awaddr, s0_axi_araddr, s1_axi_araddr} = '0;
    {s0_axi_awlen, s1_axi_awlen, s0_axi_arlen, s1_axi_arlen} = '0;
    {s0_axi_awsize, s1_axi_awsize, s0_axi_awprot, s1_axi_awprot} = '0;
    {s0_axi_arsize, s1_axi_arsize, s0_axi_arprot, s1_axi_arprot} = '0;
    {s0_axi_awburst, s1_axi_awburst, s0_axi_arburst, s1_axi_arburst} = '0;
    {s0_axi_awlock, s1_axi_awlock, s0_axi_arlock, s1_axi_arlock} = '0;
    {s0_axi_awcache, s1_axi_awcache, s0_axi_awqos, s1_axi_awqos} = '0;
    {s0_axi_awregion, s1_axi_awregion, s0_axi_arregion, s1_axi_arregion} = '0;
    {s0_axi_arcache, s1_axi_arcache, s0_axi_arqos, s1_axi_arqos} = '0;
    {s0_axi_awatop, s1_axi_awatop} = '0;
    {s0_axi_awuser, s1_axi_awuser, s0_axi_aruser, s1_axi_aruser, s0_axi_wuser, s1_axi_wuser} = '0;
    {s0_axi_awvalid, s1_axi_awvalid, s0_axi_arvalid, s1_axi_arvalid} = '0;
    {s0_axi_wdata, s1_axi_wdata, s0_axi_wstrb, s1_axi_wstrb} = '0;
    {s0_axi_wlast, s1_axi_wlast, s0_axi_wvalid, s1_axi_wvalid} = '0;
    {s0_axi_bready, s1_axi_bready, s0_axi_rready, s1_axi_rready} = '0;
    {m_axi_out_awready, m_axi_out_wready, m_axi_out_arready} = '0;
    {m_axi_out_bid, m_axi_out_bresp, m_axi_out_buser, m_axi_out_bvalid} = '0;
    {m_axi_out_rid, m_axi_out_rdata, m_axi_out_rresp, m_axi_out_rlast} = '0;
    {m_axi_out_ruser, m_axi_out_rvalid} = '0;
  endtask

  typedef struct {
    logic       bvalid;
    logic [4:0] bid;
    logic       bready0, bready1;
    logic       rvalid;
    logic [4:0] rid;
    logic       rready0, rready1;
    logic       e_bv0, e_bv1;
    logic [3:0] e_bid;
    logic       e_bready;
    logic       e_rv0, e_rv1;
    logic [3:0] e_rid;
    logic       e_rready;
  } vec_t;

  vec_t vecs [5];

  initial begin
    vecs[0] = '{1'b1, 5'b10011, 1'b0, 1'b1, 1'b1, 5'b00111, 1'b1, 1'b0,
                1'b0, 1'b1, 4'h3, 1'b1, 1'b1, 1'b0, 4'h7, 1'b1};
    vecs[1] = '{1'b1, 5'b00101, 1'b0, 1'b1, 1'b1, 5'b11010, 1'b1, 1'b0,
                1'b1, 1'b0, 4'h5, 1'b0, 1'b0, 1'b1, 4'hA, 1'b0};
    vecs[2] = '{1'b0, 5'b11111, 1'b0, 1'b1, 1'b0, 5'b01000, 1'b1, 1'b1,
                1'b0, 1'b0, 4'hF, 1'b1, 1'b0, 1'b0, 4'h8, 1'b1};
    vecs[3] = '{1'b1, 5'b01111, 1'b1, 1'b0, 1'b1, 5'b10000, 1'b0, 1'b1,
                1'b1, 1'b0, 4'hF, 1'b1, 1'b0, 1'b1, 4'h0, 1'b1};
    vecs[4] = '{1'b1, 5'b10000, 1'b1, 1'b0, 1'b1, 5'b00001, 1'b0, 1'b1,
                1'b0, 1'b1, 4'h0, 1'b0, 1'b1, 1'b0, 4'h1, 1'b0};

    clear_inputs();
    areset = 1'b1;
    s0_axi_awvalid = 1'b1;
    s1_axi_awvalid = 1'b1;
    m_axi_out_awready = 1'b1;
    m_axi_out_bvalid = 1'b1;
    s0_axi_bready = 1'b1;
    #3;
    check("reset m_awvalid", m_axi_out_awvalid, 1'b0);
    check("reset s0_awready", s0_axi_awready, 1'b0);
    check("reset s1_awready", s1_axi_awready, 1'b0);
    check("reset s0_bvalid", s0_axi_bvalid, 1'b0);
    check("reset m_bready", m_axi_out_bready, 1'b0);
    check("reset m_wvalid", m_axi_out_wvalid, 1'b0);
    tick();
    clear_inputs();
    areset = 1'b0;
    tick();

    // Both masters stream single-beat writes: grants alternate, W follows the order.
    s0_axi_awvalid = 1'b1; s1_axi_awvalid = 1'b1;
    s0_axi_awid = 4'h1;    s1_axi_awid = 4'h2;
    s0_axi_wvalid = 1'b1;  s1_axi_wvalid = 1'b1;
    s0_axi_wlast = 1'b1;   s1_axi_wlast = 1'b1;
    s0_axi_wdata = 64'hA0; s1_axi_wdata = 64'hB0;
    m_axi_out_awready = 1'b1; m_axi_out_wready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      settle();
      check($sformatf("alt%0d awid", k), m_axi_out_awid, (k % 2 == 1) ? 5'h12 : 5'h01);
      check($sformatf("alt%0d s0_awready", k), s0_axi_awready, k % 2 == 0);
      check($sformatf("alt%0d s1_awready", k), s1_axi_awready, k % 2 == 1);
      if (k == 0) begin
        check("alt0 m_wvalid", m_axi_out_wvalid, 1'b0);
      end else begin
        check($sformatf("alt%0d s0_wready", k), s0_axi_wready, (k - 1) % 2 == 0);
        check($sformatf("alt%0d s1_wready", k), s1_axi_wready, (k - 1) % 2 == 1);
        check($sformatf("alt%0d wdata", k), m_axi_out_wdata, ((k - 1) % 2 == 1) ? 64'hB0 : 64'hA0);
      end
      tick();
    end
    s0_axi_awvalid = 1'b0; s1_axi_awvalid = 1'b0;
    settle();
    check("alt drain s1_wready", s1_axi_wready, 1'b1);
    check("alt drain s0_wready", s0_axi_wready, 1'b0);
    tick();
    settle();
    check("alt empty m_wvalid", m_axi_out_wvalid, 1'b0);
    check("alt empty s0_wready", s0_axi_wready, 1'b0);
    clear_inputs();
    tick();

    // Master 0 burst of 4 beats, then master 1 single beat, strictly in AW order.
    s0_axi_awvalid = 1'b1; s0_axi_awlen = 8'd3; s0_axi_awid = 4'h4;
    s0_axi_wvalid = 1'b1;  s0_axi_wdata = 64'd100;
    m_axi_out_awready = 1'b1; m_axi_out_wready = 1'b1;
    settle();
    check("burst aw s0_awready", s0_axi_awready, 1'b1);
    check("burst aw awlen", m_axi_out_awlen, 8'd3);
    check("burst same-cycle m_wvalid", m_axi_out_wvalid, 1'b0);
    check("burst same-cycle s0_wready", s0_axi_wready, 1'b0);
    tick();
    s0_axi_awvalid = 1'b0;
    s1_axi_awvalid = 1'b1; s1_axi_awid = 4'h5;
    s1_axi_wvalid = 1'b1;  s1_axi_wlast = 1'b1; s1_axi_wdata = 64'd200;
    for (int b = 0; b < 4; b++) begin
      s0_axi_wdata = 64'(100 + b);
      s0_axi_wlast = (b == 3);
      settle();
      if (b == 0) check("burst s1 awready", s1_axi_awready, 1'b1);
      check($sformatf("burst beat%0d wdata", b), m_axi_out_wdata, 64'(100 + b));
      check($sformatf("burst beat%0d s0_wready", b), s0_axi_wready, 1'b1);
      check($sformatf("burst beat%0d s1_wready", b), s1_axi_wready, 1'b0);
      tick();
      s1_axi_awvalid = 1'b0;
    end
    s0_axi_wvalid = 1'b0;
    settle();
    check("burst m1 s1_wready", s1_axi_wready, 1'b1);
    check("burst m1 wdata", m_axi_out_wdata, 64'd200);
    tick();
    settle();
    check("burst empty s1_wready", s1_axi_wready, 1'b0);
    check("burst empty m_wvalid", m_axi_out_wvalid, 1'b0);
    clear_inputs();
    tick();

    // Fill the W-order FIFO, then free one slot and exercise push+pop in one cycle.
    s0_axi_awvalid = 1'b1; m_axi_out_awready = 1'b1; s0_axi_wlast = 1'b1;
    for (int i = 0; i < 4; i++) begin
      settle();
      check($sformatf("fill%0d s0_awready", i), s0_axi_awready, 1'b1);
      tick();
    end
    settle();
    check("full s0_awready", s0_axi_awready, 1'b0);
    check("full m_awvalid", m_axi_out_awvalid, 1'b0);
    s0_axi_wvalid = 1'b1; m_axi_out_wready = 1'b1;
    settle();
    check("full pop s0_wready", s0_axi_wready, 1'b1);
    check("full pop same-cycle awready", s0_axi_awready, 1'b0);
    tick();
    settle();
    check("reopen push+pop awready", s0_axi_awready, 1'b1);
    tick();
    s0_axi_wvalid = 1'b0;
    settle();
    check("refill awready", s0_axi_awready, 1'b1);
    tick();
    settle();
    check("full again awready", s0_axi_awready, 1'b0);
    s0_axi_awvalid = 1'b0; s0_axi_wvalid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      settle();
      check($sformatf("drain%0d s0_wready", i), s0_axi_wready, 1'b1);
      tick();
    end
    settle();
    check("drained m_wvalid", m_axi_out_wvalid, 1'b0);
    clear_inputs();
    tick();

    // AR round robin and grant lock while the adapter stalls.
    s0_axi_arvalid = 1'b1; s1_axi_arvalid = 1'b1;
    s0_axi_arid = 4'h3;    s1_axi_arid = 4'h6;
    m_axi_out_arready = 1'b1;
    settle(); check("ar0 arid", m_axi_out_arid, 5'h03); tick();
    settle(); check("ar1 arid", m_axi_out_arid, 5'h16); tick();
    s1_axi_arvalid = 1'b0;
    settle(); check("ar2 arid", m_axi_out_arid, 5'h03); tick();
    m_axi_out_arready = 1'b0;
    settle(); check("ar stall arvalid", m_axi_out_arvalid, 1'b1); tick();
    s1_axi_arvalid = 1'b1;
    settle();
    check("ar lock arid", m_axi_out_arid, 5'h03);
    check("ar lock s1_arready", s1_axi_arready, 1'b0);
    m_axi_out_arready = 1'b1;
    settle(); check("ar lock release s0_arready", s0_axi_arready, 1'b1); tick();
    settle();
    check("ar after lock arid", m_axi_out_arid, 5'h16);
    check("ar after lock s1_arready", s1_axi_arready, 1'b1);
    clear_inputs();
    tick();

    // Table-driven B / R routing.
    for (int i = 0; i < 5; i++) begin
      m_axi_out_bvalid = vecs[i].bvalid; m_axi_out_bid = vecs[i].bid;
      s0_axi_bready = vecs[i].bready0;   s1_axi_bready = vecs[i].bready1;
      m_axi_out_rvalid = vecs[i].rvalid; m_axi_out_rid = vecs[i].rid;
      s0_axi_rready = vecs[i].rready0;   s1_axi_rready = vecs[i].rready1;
      m_axi_out_rdata = 64'hC0DE_0000 + 64'(i);
      settle();
      check($sformatf("vec%0d s0_bvalid", i), s0_axi_bvalid, vecs[i].e_bv0);
      check($sformatf("vec%0d s1_bvalid", i), s1_axi_bvalid, vecs[i].e_bv1);
      check($sformatf("vec%0d s0_bid", i), s0_axi_bid, vecs[i].e_bid);
      check($sformatf("vec%0d s1_bid", i), s1_axi_bid, vecs[i].e_bid);
      check($sformatf("vec%0d m_bready", i), m_axi_out_bready, vecs[i].e_bready);
      check($sformatf("vec%0d s0_rvalid", i), s0_axi_rvalid, vecs[i].e_rv0);
      check($sformatf("vec%0d s1_rvalid", i), s1_axi_rvalid, vecs[i].e_rv1);
      check($sformatf("vec%0d s0_rid", i), s0_axi_rid, vecs[i].e_rid);
      check($sformatf("vec%0d s1_rid", i), s1_axi_rid, vecs[i].e_rid);
      check($sformatf("vec%0d m_rready", i), m_axi_out_rready, vecs[i].e_rready);
      check($sformatf("vec%0d rdata", i), s1_axi_rdata, 64'hC0DE_0000 + 64'(i));
      tick();
    end
    clear_inputs();
    tick();

    // ATOP AMOADD from master 1: both B and R come back to master 1 with its ID.
    s1_axi_awvalid = 1'b1; s1_axi_awid = 4'h9; s1_axi_awatop = 6'b100000;
    m_axi_out_awready = 1'b1;
    settle();
    check("atop awatop", m_axi_out_awatop, 6'b100000);
    check("atop awid", m_axi_out_awid, 5'h19);
    check("atop s1_awready", s1_axi_awready, 1'b1);
    tick();
    s1_axi_awvalid = 1'b0;
    s1_axi_wvalid = 1'b1; s1_axi_wlast = 1'b1; m_axi_out_wready = 1'b1;
    settle(); check("atop s1_wready", s1_axi_wready, 1'b1); tick();
    clear_inputs();
    m_axi_out_bvalid = 1'b1; m_axi_out_bid = 5'h19; s1_axi_bready = 1'b1;
    m_axi_out_rvalid = 1'b1; m_axi_out_rid = 5'h19; m_axi_out_rlast = 1'b1;
    settle();
    check("atop s1_bvalid", s1_axi_bvalid, 1'b1);
    check("atop s0_bvalid", s0_axi_bvalid, 1'b0);
    check("atop s1_bid", s1_axi_bid, 4'h9);
    check("atop m_bready", m_axi_out_bready, 1'b1);
    check("atop s1_rvalid", s1_axi_rvalid, 1'b1);
    check("atop s0_rvalid", s0_axi_rvalid, 1'b0);
    check("atop s1_rid", s1_axi_rid, 4'h9);
    clear_inputs();
    tick();

    // Reset during a granted, stalled AW; afterwards master 0 has priority again.
    s0_axi_awvalid = 1'b1; s0_axi_awid = 4'h1; m_axi_out_awready = 1'b1;
    settle(); check("pre-reset s0_awready", s0_axi_awready, 1'b1); tick();
    s0_axi_awvalid = 1'b0;
    s1_axi_awvalid = 1'b1; s1_axi_awid = 4'h2; m_axi_out_awready = 1'b0;
    settle(); check("stalled awid", m_axi_out_awid, 5'h12); tick();
    areset = 1'b1;
    s0_axi_awvalid = 1'b1; m_axi_out_awready = 1'b1;
    s0_axi_wvalid = 1'b1; s0_axi_wlast = 1'b1; m_axi_out_wready = 1'b1;
    m_axi_out_bvalid = 1'b1; m_axi_out_rvalid = 1'b1; s0_axi_bready = 1'b1;
    settle();
    check("areset m_awvalid", m_axi_out_awvalid, 1'b0);
    check("areset s0_awready", s0_axi_awready, 1'b0);
    check("areset s1_awready", s1_axi_awready, 1'b0);
    check("areset m_wvalid", m_axi_out_wvalid, 1'b0);
    check("areset s0_wready", s0_axi_wready, 1'b0);
    check("areset s0_bvalid", s0_axi_bvalid, 1'b0);
    check("areset s0_rvalid", s0_axi_rvalid, 1'b0);
    check("areset m_bready", m_axi_out_bready, 1'b0);
    tick();
    areset = 1'b0;
    m_axi_out_bvalid = 1'b0; m_axi_out_rvalid = 1'b0;
    settle();
    check("post-reset awid", m_axi_out_awid, 5'h01);
    check("post-reset s0_awready", s0_axi_awready, 1'b1);
    check("post-reset s1_awready", s1_axi_awready, 1'b0);
    check("post-reset m_wvalid", m_axi_out_wvalid, 1'b0);
    tick();
    clear_inputs();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
